// File: rtl/header_rx.sv
// header_rx: parses SYNC / length / payload [/ XOR] frames from a UART byte stream into a flat header bus.
// Define HEADER_RX_CHECKSUM_EN to require and verify a trailing XOR byte (adds the CHK state).
module header_rx #(
  parameter int         NBYTES  = 128,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 100000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  input  logic                hdr_ready_i,
  output logic [8*NBYTES-1:0] hdr_o,
  output logic                hdr_valid_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output logic                ovr_o,
  output logic                busy_o
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    LEN_BYTE = 8'(NBYTES);
  localparam logic [7:0]    LAST_IDX = 8'(NBYTES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]    ERR_LEN  = 2'd1;
  localparam logic [1:0]    ERR_TMO  = 2'd3;
`ifdef HEADER_RX_CHECKSUM_EN
  localparam logic [1:0]    ERR_CHK  = 2'd2;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
`ifdef HEADER_RX_CHECKSUM_EN
    S_CHK,
`endif
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            ovr_q, ovr_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            wr_en;
  logic            in_frame;
`ifdef HEADER_RX_CHECKSUM_EN
  logic [7:0]      xor_q, xor_d;
`endif
  logic [7:0]      slot_q [NBYTES];

  function automatic logic is_busy(input state_t s);
    logic b;
    b = (s == S_LEN) || (s == S_PAYLOAD);
`ifdef HEADER_RX_CHECKSUM_EN
    b = b || (s == S_CHK);
`endif
    return b;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    code_d  = code_q;
    ovr_d   = 1'b0;
    wr_en   = 1'b0;
`ifdef HEADER_RX_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    in_frame = is_busy(state_q);

    // Every strobe restarts the inter-byte timer, whatever the state.
    if (rx_valid_i) tmo_d = '0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid_i && rx_data_i == SYNC) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_valid_i) begin
          if (rx_data_i == LEN_BYTE) begin
            cnt_d   = '0;
`ifdef HEADER_RX_CHECKSUM_EN
            xor_d   = '0;
`endif
            state_d = S_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid_i) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 8'd1;
`ifdef HEADER_RX_CHECKSUM_EN
          xor_d = xor_q ^ rx_data_i;
          if (cnt_q == LAST_IDX) state_d = S_CHK;
`else
          if (cnt_q == LAST_IDX) state_d = S_HOLD;
`endif
        end
      end
`ifdef HEADER_RX_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid_i) begin
          if (rx_data_i == xor_q) begin
            state_d = S_HOLD;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHK;
            state_d = S_IDLE;
          end
        end
      end
`endif
      S_HOLD: begin
        if (rx_valid_i) ovr_d = 1'b1;
        if (hdr_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A byte on the same cycle as expiry wins, so the timer only acts when no strobe is present.
    if (in_frame && !rx_valid_i) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d   = TMO_MAX;
        err_d   = 1'b1;
        code_d  = ERR_TMO;
        state_d = S_IDLE;
      end else if (tmo_q != TMO_MAX) begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    busy_d  = is_busy(state_d);
    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

`ifdef HEADER_RX_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) xor_q <= '0;
    else        xor_q <= xor_d;
  end
`endif

  // One byte register per slot; slots are only written in PAYLOAD, so the bus is frozen in HOLD.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_slot
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                                slot_q[gi] <= '0;
      else if (wr_en && cnt_q == 8'(gi))         slot_q[gi] <= rx_data_i;
    end
    assign hdr_o[8*gi +: 8] = slot_q[gi];
  end

  assign hdr_valid_o = valid_q;
  assign err_o       = err_q;
  assign err_code_o  = code_q;
  assign ovr_o       = ovr_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_header_rx.sv
// Self-checking bench for header_rx: directed scenarios with random payloads against a frame-level reference.
// Follows HEADER_RX_CHECKSUM_EN the same way as the design.
module tb_header_rx;

  localparam int         NB   = 128;
  localparam int         TO   = 20;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef HEADER_RX_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic            hdr_ready = 1'b0;
  logic [8*NB-1:0] hdr;
  logic            hdr_valid, err, ovr, busy;
  logic [1:0]      err_code;

  int              n_checks = 0;
  int              n_fail = 0;
  logic [7:0]      pay [NB];
  logic [1:0]      last_code = 2'd0;
  logic [8*NB-1:0] held;
  logic [7:0]      b;

  always #5 clk = ~clk;

  header_rx #(.NBYTES(NB), .SYNC(SYNC), .TIMEOUT(TO)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .hdr_ready_i(hdr_ready),
    .hdr_o      (hdr),
    .hdr_valid_o(hdr_valid),
    .err_o      (err),
    .err_code_o (err_code),
    .ovr_o      (ovr),
    .busy_o     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_hdr(input string tag, input logic [8*NB-1:0] expv);
    n_checks++;
    assert (hdr === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, hdr, expv);
    end
  endtask

  // One clock cycle: inputs change on the falling edge, outputs are looked at 1ns after the rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    rx_valid  = v;
    rx_data   = d;
    hdr_ready = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8*NB-1:0] packed_payload();
    logic [8*NB-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) r[8*k +: 8] = pay[k];
    return r;
  endfunction

  function automatic logic [7:0] payload_xor();
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < NB; k++) r = r ^ pay[k];
    return r;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < NB; k++) pay[k] = 8'($urandom);
  endtask

  task automatic send_noise(input int n);
    logic [7:0] nb;
    for (int i = 0; i < n; i++) begin
      nb = 8'($urandom);
      if (nb == SYNC) nb = 8'h00;
      step(1'b1, nb, 1'($urandom));
      chk("noise_not_busy", busy, 0);
    end
  endtask

  // Full frame from pay[]; optional silent gap before payload byte gap_at; checksum XORed with flip.
  task automatic send_frame(input int gap_at, input int gap_len, input logic [7:0] flip);
    step(1'b1, SYNC, 1'($urandom));
    chk("busy_after_sync", busy, 1);
    step(1'b1, 8'(NB), 1'($urandom));
    for (int k = 0; k < NB; k++) begin
      if (k == gap_at)
        for (int g = 0; g < gap_len; g++) step(1'b0, 8'($urandom), 1'($urandom));
      step(1'b1, pay[k], (k == NB-1) ? 1'b0 : 1'($urandom));
      if (k < NB-1 || CHK_EN) chk("no_valid_mid_frame", hdr_valid, 0);
    end
    if (CHK_EN) step(1'b1, payload_xor() ^ flip, 1'b0);
  endtask

  task automatic expect_good();
    chk("valid_after_last", hdr_valid, 1);
    chk_hdr("hdr_contents", packed_payload());
    chk("busy_in_hold", busy, 0);
    chk("err_in_hold", err, 0);
    chk("code_held", err_code, last_code);
  endtask

  task automatic release_hdr();
    step(1'b0, 8'h00, 1'b0);
    chk("valid_holds", hdr_valid, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("valid_drops", hdr_valid, 0);
    chk("busy_after_xfer", busy, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_hdr("rst_hdr", '0);
    chk("rst_valid", hdr_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_valid", hdr_valid, 0);
    chk("post_rst_busy", busy, 0);

    // Good frame with payload 00..7F
    for (int k = 0; k < NB; k++) pay[k] = 8'(k);
    send_noise(4);
    send_frame(-1, 0, 8'h00);
    expect_good();
    chk("hdr_byte0", hdr[7:0], 8'h00);
    chk("hdr_byte127", hdr[8*NB-1 -: 8], 8'h7F);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("valid_waits_ready", hdr_valid, 1);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("valid_after_ready", hdr_valid, 0);

    // Bad length, then a normal frame
    step(1'b1, SYNC, 1'b0);
    step(1'b1, 8'h7F, 1'b0);
    last_code = 2'd1;
    chk("badlen_err", err, 1);
    chk("badlen_code", err_code, 1);
    chk("badlen_busy", busy, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("badlen_pulse_end", err, 0);
    chk("badlen_code_holds", err_code, 1);
    fill_random();
    send_frame(-1, 0, 8'h00);
    expect_good();
    release_hdr();

    // Longest silent gap that must not time out
    fill_random();
    send_frame(NB/2, TO-1, 8'h00);
    expect_good();
    release_hdr();

`ifdef HEADER_RX_CHECKSUM_EN
    // Bad checksum: payload all 01 has XOR 00, send 01
    for (int k = 0; k < NB; k++) pay[k] = 8'h01;
    send_frame(-1, 0, 8'h01);
    last_code = 2'd2;
    chk("badchk_err", err, 1);
    chk("badchk_code", err_code, 2);
    chk("badchk_valid", hdr_valid, 0);
    chk("badchk_busy", busy, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("badchk_pulse_end", err, 0);
    chk("badchk_valid_stays", hdr_valid, 0);
`endif

    // Timeout: error exactly TO cycles after the last strobe
    fill_random();
    step(1'b1, SYNC, 1'b0);
    step(1'b1, 8'(NB), 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, pay[k], 1'b0);
    for (int i = 1; i <= TO; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (i < TO) begin
        chk("tmo_no_err_yet", err, 0);
        chk("tmo_still_busy", busy, 1);
      end else begin
        last_code = 2'd3;
        chk("tmo_err", err, 1);
        chk("tmo_code", err_code, 3);
        chk("tmo_busy_falls", busy, 0);
      end
    end
    step(1'b0, 8'h00, 1'b0);
    chk("tmo_pulse_end", err, 0);
    chk("tmo_no_valid", hdr_valid, 0);

    // Overrun in HOLD: bytes dropped (first one SYNC), bus frozen
    fill_random();
    send_frame(-1, 0, 8'h00);
    expect_good();
    held = packed_payload();
    for (int i = 0; i < 3; i++) begin
      b = (i == 0) ? SYNC : 8'($urandom);
      step(1'b1, b, 1'b0);
      chk("ovr_pulse", ovr, 1);
      chk_hdr("ovr_hdr_frozen", held);
      chk("ovr_valid_holds", hdr_valid, 1);
      step(1'b0, 8'h00, 1'b0);
      chk("ovr_pulse_end", ovr, 0);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("ovr_release_valid", hdr_valid, 0);
    chk("ovr_release_busy", busy, 0);

    // Random frames with noise and random in-frame gaps
    for (int f = 0; f < 3; f++) begin
      fill_random();
      send_noise(int'($urandom_range(0, 5)));
      send_frame(int'($urandom_range(0, NB-1)), int'($urandom_range(0, TO-1)), 8'h00);
      expect_good();
      release_hdr();
    end

    // Asynchronous reset after payload byte 50
    fill_random();
    step(1'b1, SYNC, 1'b0);
    step(1'b1, 8'(NB), 1'b0);
    for (int k = 0; k <= 50; k++) step(1'b1, pay[k], 1'b0);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    #1;
    last_code = 2'd0;
    chk_hdr("arst_hdr", '0);
    chk("arst_valid", hdr_valid, 0);
    chk("arst_err", err, 0);
    chk("arst_code", err_code, 0);
    chk("arst_ovr", ovr, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    send_frame(-1, 0, 8'h00);
    expect_good();
    release_hdr();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
